adc_scan_scheduler: RTL
=======================

Name: adc_scan_scheduler

Overview:
Sequences the 12-bit SPI ADC front end through a programmable set of input channels at a fixed sample rate. A prescaler generates a scan tick. On each tick the block issues one conversion request per enabled channel to the SPI state machine, then tags each returned result with its channel. It sits between the SPI master and the downstream consumers (LED/threshold logic, display), replacing the free-running conversion loop.

Parameters:
CLK_DIV, 1000, clock cycles between scan ticks (period of the prescaler, minimum 2)
NUM_CH, 4, number of ADC channels scanned (2..8)
CH_W, 2, channel index width, equal to clog2(NUM_CH)
DATA_W, 12, ADC result width
TIMEOUT, 255, maximum cycles to wait for spi_done after spi_start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable
ch_mask  in  NUM_CH  channel enable mask; bit i set means channel i is scanned
err_clr  in  1  one-cycle pulse; clears sticky error flags
spi_start  out  1  one-cycle conversion request to the SPI master
spi_channel  out  CH_W  channel for the current request; held stable from spi_start until completion
spi_busy  in  1  SPI master busy
spi_done  in  1  one-cycle pulse; spi_data is valid in the same cycle
spi_data  in  DATA_W  conversion result
sample_valid  out  1  one-cycle pulse; a new tagged sample is on sample_ch and sample_data
sample_ch  out  CH_W  channel of the sample
sample_data  out  DATA_W  sample value
scan_done  out  1  one-cycle pulse after the last channel of a scan completes
overrun_err  out  1  sticky; a tick arrived while a scan was still in progress
timeout_err  out  1  sticky; a conversion exceeded TIMEOUT

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the prescaler is 0, and the mask snapshot is 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while ena=1 and wraps at CLK_DIV-1. tick is high in the wrap cycle.
  - When ena=0 the prescaler is held at 0.
- FSM states: IDLE, ISSUE, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - On tick with ena=1 and ch_mask!=0: snapshot ch_mask, select the lowest set bit as the channel, go to ISSUE.
  - On tick with ch_mask==0: stay in IDLE; no pulses.
- ISSUE:
  - Wait until spi_busy=0.
  - Then pulse spi_start for one cycle with spi_channel set, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - On spi_done: capture spi_data. In the next cycle, pulse sample_valid with sample_ch equal to the current channel. Go to NEXT.
  - If TIMEOUT cycles elapse with no spi_done: set timeout_err, emit no sample, go to NEXT.
  - A spi_done arriving in any other state is ignored.
- NEXT:
  - If a higher set bit remains in the snapshot: select it, go to ISSUE.
  - Otherwise go to FINISH.
- FINISH: pulse scan_done for one cycle, go to IDLE.
- Scan order: ascending channel index. Mask changes during a scan take effect at the next scan.
- Overrun: a tick in any state other than IDLE sets overrun_err. That tick is dropped; no queued scan results.
- ena deasserted mid-scan: the outstanding conversion completes (done or timeout) and its sample is still emitted. The FSM then goes to IDLE without issuing the remaining channels and without a scan_done pulse.
- err_clr clears both sticky flags. If a set event and err_clr occur in the same cycle, set wins.
- Latency: spi_done to sample_valid is exactly 1 cycle. The final sample_valid to scan_done is 2 cycles.
- sample_ch and sample_data hold their last values between pulses.

Optional Feature:
ADC_AVG_EN
- Defined:
  - Each channel keeps a 4-deep history (reset to 0) and a running sum of DATA_W+2 bits.
  - sample_data is (sum of the last 4 samples)>>2, truncated. For example, the first sample 0x800 after reset gives 0x200.
  - The history updates only on accepted spi_done. Latency is unchanged at 1 cycle.
- Not defined: sample_data is the raw spi_data. No history storage exists.

Test Plan:
1. CLK_DIV=16, ch_mask=4'b1011, spi_done returns 0x123/0x456/0x789 -> sample_valid with ch 0,1,3 and those values in that order, then scan_done 2 cycles after the last sample; next scan starts 16 cycles after the previous tick.
2. ch_mask=0 for 3 ticks -> no spi_start, no scan_done, no error flags set.
3. Channel 1 never returns spi_done (TIMEOUT=255) -> timeout_err=1 exactly 255 cycles after spi_start; no sample for ch1; ch3 still converted; err_clr drops the flag.
4. spi_done delayed past one tick period -> overrun_err=1; the current scan completes normally; the dropped tick produces no extra scan.
5. spi_busy held high 10 cycles at ISSUE -> spi_start is emitted on the first cycle spi_busy=0; ena dropped during ch0 -> ch0 sample still emitted, then IDLE with no scan_done; rst_n asserted mid-WAIT_DONE -> all outputs 0 immediately.
6. ADC_AVG_EN defined, ch0 fed 0x800 four times -> sample_data 0x200, 0x400, 0x600, 0x800.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: prescaled channel scan sequencer for a 12-bit SPI ADC.
// Build macro ADC_AVG_EN: when defined, sample_data is a 4-deep per-channel
// moving average instead of the raw conversion result.
//
// Handshakes: spi_start is a one-cycle request raised only while spi_busy is
// low; spi_channel is held from that cycle until spi_done (one-cycle pulse,
// spi_data valid in the same cycle) or a timeout. sample_valid and scan_done
// are one-cycle pulses with no back-pressure; sample_ch/sample_data hold
// their last values between pulses.
module adc_scan_scheduler #(
    parameter int CLK_DIV = 1000,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              err_clr,
    output logic              spi_start,
    output logic [CH_W-1:0]   spi_channel,
    input  logic              spi_busy,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_data,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              scan_done,
    output logic              overrun_err,
    output logic              timeout_err
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    // The start cycle counts as the first waited cycle, so the last WAIT_DONE
    // cycle is reached when the counter (cleared at start) hits TIMEOUT-2.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        NEXT      = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_CH-1:0]   snap;
    logic [TO_W-1:0]     to_cnt;
    logic [CH_W-1:0]     first_ch, next_ch;
    logic                next_found;
    logic                scan_load, step, capture, to_fire, finish;
    logic [DATA_W-1:0]   sample_next;

    assign tick = ena && (div_cnt == DIV_W'(CLK_DIV - 1));

    // Prescaler: free-running 0..CLK_DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       div_cnt <= '0;
        else if (!ena)    div_cnt <= '0;
        else if (tick)    div_cnt <= '0;
        else              div_cnt <= div_cnt + DIV_W'(1);
    end

    // Lowest set bit of the live mask selects the first channel of a scan.
    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ch_mask[i]) first_ch = CH_W'(i);
    end

    // Lowest snapshot bit above the current channel selects the next one.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (snap[i] && (i > int'(spi_channel))) begin
                next_ch    = CH_W'(i);
                next_found = 1'b1;
            end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        scan_load = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        to_fire   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (tick && (|ch_mask)) begin
                    scan_load = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (!spi_busy) begin
                    spi_start = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    capture   = 1'b1;
                    state_nxt = NEXT;
                end else if (to_cnt == TO_LAST) begin
                    to_fire   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (!ena) begin
                    state_nxt = IDLE;
                end else if (next_found) begin
                    step      = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Scan datapath: snapshot, channel select, timeout counter, sample and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap         <= '0;
            spi_channel  <= '0;
            to_cnt       <= '0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= capture;
            scan_done    <= finish;
            if (scan_load) begin
                snap        <= ch_mask;
                spi_channel <= first_ch;
            end else if (step) begin
                spi_channel <= next_ch;
            end
            if (spi_start)               to_cnt <= '0;
            else if (state == WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);
            if (capture) begin
                sample_ch   <= spi_channel;
                sample_data <= sample_next;
            end
            if (tick && (state != IDLE)) overrun_err <= 1'b1;
            else if (err_clr)            overrun_err <= 1'b0;
            if (to_fire)                 timeout_err <= 1'b1;
            else if (err_clr)            timeout_err <= 1'b0;
        end
    end

`ifdef ADC_AVG_EN
    logic [DATA_W-1:0] hist [NUM_CH][4];
    logic [DATA_W+1:0] sum  [NUM_CH];
    logic [DATA_W+1:0] sum_new;

    // Running sum drops the oldest entry and adds the incoming result.
    assign sum_new     = sum[spi_channel] - {2'b00, hist[spi_channel][3]} + {2'b00, spi_data};
    assign sample_next = sum_new[DATA_W+1:2];

    // Per-channel history, advanced only on an accepted conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum[c] <= '0;
                for (int k = 0; k < 4; k++) hist[c][k] <= '0;
            end
        end else if (capture) begin
            hist[spi_channel][0] <= spi_data;
            hist[spi_channel][1] <= hist[spi_channel][0];
            hist[spi_channel][2] <= hist[spi_channel][1];
            hist[spi_channel][3] <= hist[spi_channel][2];
            sum[spi_channel]     <= sum_new;
        end
    end
`else
    assign sample_next = spi_data;
`endif

endmodule
